// File: rtl/audio_ctrl.sv
// Mode controller and SRAM arbiter for the audio recorder: turns key pulses into
// recorder/player commands and shares the single SRAM port between them.
module audio_ctrl #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_start,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic              i_sw,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic              i_rec_finish,
    input  logic              i_rec_sram_we,
    input  logic [ADDR_W-1:0] i_rec_sram_addr,
    input  logic [15:0]       i_rec_sram_wdata,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic [ADDR_W-1:0] o_play_start_addr,
    output logic [ADDR_W-1:0] o_play_end_addr,
    input  logic              i_play_finish,
    input  logic [ADDR_W-1:0] i_play_sram_addr,
    output logic [15:0]       o_play_sram_dq,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_wdata,
    input  logic [15:0]       i_sram_rdata,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_ce_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n,
    output logic              o_sram_drive,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REC        = 3'd1,
        REC_PAUSE  = 3'd2,
        PLAY       = 3'd3,
        PLAY_PAUSE = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_rec_reg, owner_rec_next;
    logic              guard_reg, guard_next;
    logic              rec_valid_reg, rec_valid_next;
    logic [ADDR_W-1:0] end_addr_reg, end_addr_next;
    logic              rec_start_reg, rec_start_next;
    logic              rec_pause_reg, rec_pause_next;
    logic              rec_stop_reg, rec_stop_next;
    logic              play_start_reg, play_start_next;
    logic              play_pause_reg, play_pause_next;
    logic              play_stop_reg, play_stop_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            owner_rec_reg  <= 1'b0;
            guard_reg      <= 1'b0;
            rec_valid_reg  <= 1'b0;
            end_addr_reg   <= '0;
            rec_start_reg  <= 1'b0;
            rec_pause_reg  <= 1'b0;
            rec_stop_reg   <= 1'b0;
            play_start_reg <= 1'b0;
            play_pause_reg <= 1'b0;
            play_stop_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_rec_reg  <= owner_rec_next;
            guard_reg      <= guard_next;
            rec_valid_reg  <= rec_valid_next;
            end_addr_reg   <= end_addr_next;
            rec_start_reg  <= rec_start_next;
            rec_pause_reg  <= rec_pause_next;
            rec_stop_reg   <= rec_stop_next;
            play_start_reg <= play_start_next;
            play_pause_reg <= play_pause_next;
            play_stop_reg  <= play_stop_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rec_valid_next  = rec_valid_reg;
        end_addr_next   = end_addr_reg;
        rec_start_next  = 1'b0;
        rec_pause_next  = 1'b0;
        rec_stop_next   = 1'b0;
        play_start_next = 1'b0;
        play_pause_next = 1'b0;
        play_stop_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_key_start) begin
                    if (i_sw) begin
                        state_next     = REC;
                        rec_start_next = 1'b1;
                        rec_valid_next = 1'b0;
                    end else if (rec_valid_reg) begin
                        state_next      = PLAY;
                        play_start_next = 1'b1;
                    end
                end
            end
            REC, REC_PAUSE: begin
                // Stop and finish share the end-of-recording bookkeeping; a finish in
                // the same cycle as stop still pins the end address to MAX_ADDR.
                if (i_key_stop || i_rec_finish) begin
                    state_next     = IDLE;
                    rec_stop_next  = i_key_stop;
                    end_addr_next  = i_rec_finish ? MAX_ADDR : i_rec_addr - ADDR_W'(1);
                    rec_valid_next = (i_rec_addr != '0) || i_rec_finish;
                end else if (i_key_pause && state_reg == REC) begin
                    state_next     = REC_PAUSE;
                    rec_pause_next = 1'b1;
                end else if (i_key_start && state_reg == REC_PAUSE) begin
                    state_next     = REC;
                    rec_start_next = 1'b1;
                end
            end
            PLAY, PLAY_PAUSE: begin
                if (i_key_stop) begin
                    state_next     = IDLE;
                    play_stop_next = 1'b1;
                end else if (i_play_finish && state_reg == PLAY) begin
                    state_next = IDLE;
                end else if (i_key_pause && state_reg == PLAY) begin
                    state_next      = PLAY_PAUSE;
                    play_pause_next = 1'b1;
                end else if (i_key_start && state_reg == PLAY_PAUSE) begin
                    state_next      = PLAY;
                    play_start_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        owner_rec_next = (state_next == REC) || (state_next == REC_PAUSE);
        // One dead cycle when the recorder hands the bus back, so it stops driving
        // DQ before the SRAM is allowed to drive it.
        guard_next     = owner_rec_reg && !owner_rec_next;
    end

    always_comb begin
        o_sram_wdata = i_rec_sram_wdata;
        if (owner_rec_reg) begin
            o_sram_addr  = i_rec_sram_addr;
            o_sram_we_n  = ~i_rec_sram_we;
            o_sram_drive = i_rec_sram_we;
            o_sram_oe_n  = 1'b1;
        end else begin
            o_sram_addr  = i_play_sram_addr;
            o_sram_we_n  = 1'b1;
            o_sram_drive = 1'b0;
            o_sram_oe_n  = 1'b0;
        end
        if (guard_reg) begin
            o_sram_we_n  = 1'b1;
            o_sram_oe_n  = 1'b1;
            o_sram_drive = 1'b0;
        end
    end

    assign o_sram_ce_n       = 1'b0;
    assign o_sram_lb_n       = 1'b0;
    assign o_sram_ub_n       = 1'b0;
    assign o_play_sram_dq    = i_sram_rdata;
    assign o_play_start_addr = '0;
    assign o_play_end_addr   = end_addr_reg;
    assign o_state           = state_reg;
    assign o_rec_start       = rec_start_reg;
    assign o_rec_pause       = rec_pause_reg;
    assign o_rec_stop        = rec_stop_reg;
    assign o_play_start      = play_start_reg;
    assign o_play_pause      = play_pause_reg;
    assign o_play_stop       = play_stop_reg;

endmodule

// File: tb/tb_audio_ctrl.sv
// Directed bench for audio_ctrl: each task drives one scenario and checks
// hand-computed command pulses, state and SRAM control values.
module tb_audio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_start = 1'b0, key_pause = 1'b0, key_stop = 1'b0, sw = 1'b0;
    logic        rec_start, rec_pause, rec_stop;
    logic [19:0] rec_addr = '0;
    logic        rec_finish = 1'b0, rec_sram_we = 1'b0;
    logic [19:0] rec_sram_addr = '0;
    logic [15:0] rec_sram_wdata = '0;
    logic        play_start, play_pause, play_stop;
    logic [19:0] play_start_addr, play_end_addr;
    logic        play_finish = 1'b0;
    logic [19:0] play_sram_addr = 20'h12345;
    logic [15:0] play_sram_dq;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata = 16'hBEEF;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n, sram_drive;
    logic [2:0]  state;

    int vectors = 0;
    int miscompares = 0;

    audio_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_key_start(key_start), .i_key_pause(key_pause), .i_key_stop(key_stop), .i_sw(sw),
        .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
        .i_rec_addr(rec_addr), .i_rec_finish(rec_finish), .i_rec_sram_we(rec_sram_we),
        .i_rec_sram_addr(rec_sram_addr), .i_rec_sram_wdata(rec_sram_wdata),
        .o_play_start(play_start), .o_play_pause(play_pause), .o_play_stop(play_stop),
        .o_play_start_addr(play_start_addr), .o_play_end_addr(play_end_addr),
        .i_play_finish(play_finish), .i_play_sram_addr(play_sram_addr),
        .o_play_sram_dq(play_sram_dq),
        .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata),
        .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n), .o_sram_ce_n(sram_ce_n),
        .o_sram_lb_n(sram_lb_n), .o_sram_ub_n(sram_ub_n), .o_sram_drive(sram_drive),
        .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs all six command pulses as {rs, rp, rt, ps, pp, pt}.
    function automatic logic [5:0] pulses();
        return {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #3;
        vectors++;
        if (state !== 3'd0 || pulses() !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d pulses=%b, want state=0 pulses=000000", state, pulses());
        end
        vectors++;
        if ({sram_we_n, sram_oe_n, sram_drive} !== 3'b100 || sram_addr !== 20'h12345) begin
            miscompares++;
            $display("FAIL reset_sram: we/oe/drv=%b addr=%h, want 100 addr=12345",
                     {sram_we_n, sram_oe_n, sram_drive}, sram_addr);
        end
        vectors++;
        if (play_end_addr !== 20'h0 || play_start_addr !== 20'h0 ||
            {sram_ce_n, sram_lb_n, sram_ub_n} !== 3'b000 || play_sram_dq !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL reset_misc: end=%h start=%h ce/lb/ub=%b dq=%h, want 0 0 000 beef",
                     play_end_addr, play_start_addr, {sram_ce_n, sram_lb_n, sram_ub_n}, play_sram_dq);
        end
        tick();
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_record();
        sw = 1'b1; key_start = 1'b1;
        tick();
        key_start = 1'b0;
        vectors++;
        if (pulses() !== 6'b100000 || state !== 3'd1) begin
            miscompares++;
            $display("FAIL rec_start: pulses=%b state=%0d, want 100000 state=1", pulses(), state);
        end
        // start while running is ignored; the previous pulse must have dropped
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        vectors++;
        if (pulses() !== 6'b0 || state !== 3'd1) begin
            miscompares++;
            $display("FAIL rec_start_again: pulses=%b state=%0d, want 000000 state=1", pulses(), state);
        end
        rec_addr = 20'h00400; key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        vectors++;
        if (pulses() !== 6'b001000 || state !== 3'd0 || play_end_addr !== 20'h003FF) begin
            miscompares++;
            $display("FAIL rec_stop: pulses=%b state=%0d end=%h, want 001000 state=0 end=003ff",
                     pulses(), state, play_end_addr);
        end
        tick();
        vectors++;
        if (pulses() !== 6'b0) begin
            miscompares++;
            $display("FAIL rec_stop_width: pulses=%b, want 000000", pulses());
        end
        $display("test_record done");
    endtask

    task automatic test_play();
        sw = 1'b0; key_start = 1'b1;
        tick();
        key_start = 1'b0;
        vectors++;
        if (pulses() !== 6'b000100 || state !== 3'd3 || sram_oe_n !== 1'b0 || sram_we_n !== 1'b1) begin
            miscompares++;
            $display("FAIL play_start: pulses=%b state=%0d oe_n=%b we_n=%b, want 000100 3 0 1",
                     pulses(), state, sram_oe_n, sram_we_n);
        end
        play_sram_addr = 20'h00077;
        #1;
        vectors++;
        if (sram_addr !== 20'h00077) begin
            miscompares++;
            $display("FAIL play_addr: addr=%h, want 00077", sram_addr);
        end
        tick();
        play_finish = 1'b1;
        tick();
        play_finish = 1'b0;
        vectors++;
        if (pulses() !== 6'b0 || state !== 3'd0) begin
            miscompares++;
            $display("FAIL play_finish: pulses=%b state=%0d, want 000000 state=0", pulses(), state);
        end
        $display("test_play done");
    endtask

    task automatic test_pause_resume();
        logic [5:0] want_p [4] = '{6'b100000, 6'b010000, 6'b100000, 6'b001000};
        logic [2:0] want_s [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
        sw = 1'b1; rec_addr = 20'h00010;
        for (int i = 0; i < 4; i++) begin
            key_start = (i == 0 || i == 2);
            key_pause = (i == 1);
            key_stop  = (i == 3);
            tick();
            {key_start, key_pause, key_stop} = 3'b000;
            vectors++;
            if (pulses() !== want_p[i] || state !== want_s[i]) begin
                miscompares++;
                $display("FAIL pause_resume_%0d: pulses=%b state=%0d, want %b state=%0d",
                         i, pulses(), state, want_p[i], want_s[i]);
            end
        end
        vectors++;
        if (play_end_addr !== 20'h0000F) begin
            miscompares++;
            $display("FAIL pause_resume_end: end=%h, want 0000f", play_end_addr);
        end
        tick();
        $display("test_pause_resume done");
    endtask

    task automatic test_priority();
        sw = 1'b0; key_start = 1'b1;
        tick();
        key_start = 1'b0;
        key_pause = 1'b1; key_stop = 1'b1;
        tick();
        key_pause = 1'b0; key_stop = 1'b0;
        vectors++;
        if (pulses() !== 6'b000001 || state !== 3'd0) begin
            miscompares++;
            $display("FAIL play_pause_stop: pulses=%b state=%0d, want 000001 state=0", pulses(), state);
        end
        sw = 1'b1; key_start = 1'b1;
        tick();
        key_start = 1'b0; sw = 1'b0;
        rec_addr = 20'h00123; key_stop = 1'b1; rec_finish = 1'b1;
        tick();
        key_stop = 1'b0; rec_finish = 1'b0;
        vectors++;
        if (pulses() !== 6'b001000 || state !== 3'd0 || play_end_addr !== 20'hFFFFF) begin
            miscompares++;
            $display("FAIL rec_stop_finish: pulses=%b state=%0d end=%h, want 001000 0 fffff",
                     pulses(), state, play_end_addr);
        end
        tick();
        $display("test_priority done");
    endtask

    task automatic test_no_recording();
        sw = 1'b1; key_start = 1'b1;
        tick();
        key_start = 1'b0;
        rec_addr = 20'h0; key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        sw = 1'b0; key_start = 1'b1;
        tick();
        key_start = 1'b0;
        vectors++;
        if (pulses() !== 6'b0 || state !== 3'd0) begin
            miscompares++;
            $display("FAIL no_rec_play: pulses=%b state=%0d, want 000000 state=0", pulses(), state);
        end
        // a fresh recording, then lost through reset mid-operation
        sw = 1'b1; rec_addr = 20'h00050; key_start = 1'b1;
        tick();
        key_start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (state !== 3'd0 || pulses() !== 6'b0 || sram_oe_n !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: state=%0d pulses=%b oe_n=%b, want 0 000000 0", state, pulses(), sram_oe_n);
        end
        tick();
        rst = 1'b0;
        sw = 1'b0; key_start = 1'b1;
        tick();
        key_start = 1'b0;
        vectors++;
        if (pulses() !== 6'b0 || state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_lost_rec: pulses=%b state=%0d, want 000000 state=0", pulses(), state);
        end
        $display("test_no_recording done");
    endtask

    task automatic test_ownership();
        sw = 1'b1; key_start = 1'b1;
        tick();
        key_start = 1'b0;
        rec_sram_we = 1'b1; rec_sram_addr = 20'hABCDE; rec_sram_wdata = 16'h5A5A;
        #1;
        vectors++;
        if ({sram_we_n, sram_oe_n, sram_drive} !== 3'b011 || sram_addr !== 20'hABCDE || sram_wdata !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL own_rec_write: we/oe/drv=%b addr=%h wd=%h, want 011 abcde 5a5a",
                     {sram_we_n, sram_oe_n, sram_drive}, sram_addr, sram_wdata);
        end
        rec_sram_we = 1'b0;
        #1;
        vectors++;
        if ({sram_we_n, sram_oe_n, sram_drive} !== 3'b110) begin
            miscompares++;
            $display("FAIL own_rec_idle: we/oe/drv=%b, want 110", {sram_we_n, sram_oe_n, sram_drive});
        end
        rec_sram_we = 1'b1; rec_addr = 20'h00200; key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        vectors++;
        if ({sram_we_n, sram_oe_n, sram_drive} !== 3'b110 || sram_addr !== 20'h00077) begin
            miscompares++;
            $display("FAIL own_guard: we/oe/drv=%b addr=%h, want 110 00077",
                     {sram_we_n, sram_oe_n, sram_drive}, sram_addr);
        end
        tick();
        rec_sram_we = 1'b0;
        vectors++;
        if ({sram_we_n, sram_oe_n, sram_drive} !== 3'b100) begin
            miscompares++;
            $display("FAIL own_after_guard: we/oe/drv=%b, want 100", {sram_we_n, sram_oe_n, sram_drive});
        end
        $display("test_ownership done");
    endtask

    initial begin
        test_reset();
        test_record();
        test_play();
        test_pause_resume();
        test_priority();
        test_no_recording();
        test_ownership();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
